// File: rtl/ps2_key_latch.sv
// PS/2 set-2 receiver and key-state latch for six game keys, presented as
// 16-bit status words {14'b0, held, latched} to the memory controller.

module ps2_key_cell #(
  parameter logic [7:0] CODE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_vld,
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       brk,
  input  logic       kbd_rst,
  output logic       held,
  output logic       latched
);
  logic hit, make;

  assign hit  = code_vld && !ext && (code == CODE);
  assign make = hit && !brk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held    <= 1'b0;
      latched <= 1'b0;
    end else begin
      if (hit) held <= !brk;
      // A make in the same cycle as the clear strobe keeps the key latched.
      latched <= make | (latched & ~kbd_rst);
    end
  end
endmodule

module ps2_key_latch #(
  parameter int         FILTER_LEN = 4,
  parameter int         TIMEOUT    = 50000,
  parameter logic [7:0] CODE_FWD   = 8'h1D,
  parameter logic [7:0] CODE_BACK  = 8'h1B,
  parameter logic [7:0] CODE_RIGHT = 8'h23,
  parameter logic [7:0] CODE_LEFT  = 8'h1C,
  parameter logic [7:0] CODE_SHOOT = 8'h29,
  parameter logic [7:0] CODE_RESET = 8'h76
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        Keyboard_reset,
  output logic [15:0] FORWARD_Out,
  output logic [15:0] BACKWARD_Out,
  output logic [15:0] TURNRIGHT_Out,
  output logic [15:0] TURNLEFT_Out,
  output logic [15:0] SHOOT_Out,
  output logic [15:0] RESET_Out,
  output logic        frame_err
);
  localparam int NUM_KEYS = 6;
  localparam int FCW      = $clog2(FILTER_LEN + 1);
  localparam int TOW      = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TOW-1:0] TO_MAX   = TOW'(TIMEOUT - 1);
  localparam logic [NUM_KEYS-1:0][7:0] KEY_CODES =
    {CODE_RESET, CODE_SHOOT, CODE_LEFT, CODE_RIGHT, CODE_BACK, CODE_FWD};

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronizers reset to the idle-high bus level.
  logic [1:0] clk_sync, data_sync;
  logic       s_clk, s_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign s_clk  = clk_sync[1];
  assign s_data = data_sync[1];

  // Glitch filter on the PS/2 clock; level flips after FILTER_LEN agreeing samples.
  logic           filt, filt_d, fall_evt;
  logic [FCW-1:0] filt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (s_clk == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt     <= s_clk;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall_evt = filt_d & ~filt;

  // Receive FSM
  state_t         state, state_nx;
  logic [7:0]     shreg, shreg_nx;
  logic [2:0]     bit_cnt, bit_cnt_nx;
  logic           par_bit, par_nx;
  logic [TOW-1:0] to_cnt;
  logic           timeout, done, err;

  assign timeout = (state != IDLE) && !fall_evt && (to_cnt == TO_MAX);

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    par_nx     = par_bit;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: if (fall_evt && !s_data) begin
        state_nx   = DATA;
        bit_cnt_nx = 3'd0;
      end
      DATA: if (fall_evt) begin
        shreg_nx   = {s_data, shreg[7:1]};
        bit_cnt_nx = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nx = PARITY;
      end
      PARITY: if (fall_evt) begin
        par_nx   = s_data;
        state_nx = STOP;
      end
      STOP: if (fall_evt) begin
        if (s_data && (^{shreg, par_bit})) done = 1'b1;
        else                               err  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (timeout) begin
      state_nx = IDLE;
      err      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      par_bit <= par_nx;
      if (state == IDLE || fall_evt || timeout) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Accepted byte is handed to the decoder one cycle after the stop bit.
  logic       rx_vld;
  logic [7:0] rx_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_vld    <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_vld    <= done;
      rx_byte   <= shreg;
      frame_err <= err;
    end
  end

  // Prefix tracking: E0/F0 arm flags consumed by the next real code.
  logic ext, brk, code_vld;

  assign code_vld = rx_vld && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (rx_vld) begin
      if (rx_byte == 8'hE0) begin
        ext <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  logic [NUM_KEYS-1:0] held, latched;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    ps2_key_cell #(.CODE(KEY_CODES[k])) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .code_vld (code_vld),
      .code     (rx_byte),
      .ext      (ext),
      .brk      (brk),
      .kbd_rst  (Keyboard_reset),
      .held     (held[k]),
      .latched  (latched[k])
    );
  end

  assign FORWARD_Out   = {14'b0, held[0], latched[0]};
  assign BACKWARD_Out  = {14'b0, held[1], latched[1]};
  assign TURNRIGHT_Out = {14'b0, held[2], latched[2]};
  assign TURNLEFT_Out  = {14'b0, held[3], latched[3]};
  assign SHOOT_Out     = {14'b0, held[4], latched[4]};
  assign RESET_Out     = {14'b0, held[5], latched[5]};
endmodule

// File: tb/tb_ps2_key_latch.sv
// Directed bench for ps2_key_latch: drives PS/2 frames bit by bit and
// checks the six status words and frame_err against hand-computed values.

module tb_ps2_key_latch;
  localparam int TIMEOUT = 50000;
  localparam int H       = 20;

  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, kbd_rst = 1'b0;
  logic [15:0] fwd, back, right, left, shoot, esc;
  logic frame_err;
  int checks = 0, errors = 0, err_cnt = 0;

  always #5 clk = ~clk;

  ps2_key_latch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .Keyboard_reset (kbd_rst),
    .FORWARD_Out    (fwd),
    .BACKWARD_Out   (back),
    .TURNRIGHT_Out  (right),
    .TURNLEFT_Out   (left),
    .SHOOT_Out      (shoot),
    .RESET_Out      (esc),
    .frame_err      (frame_err)
  );

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fwd, back, right, left, shoot, esc} !== 96'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h %h %h %h %h %h want all 0000", fwd, back, right, left, shoot, esc);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b want 0", frame_err);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h1D, 1'b0);
    checks++;
    if (fwd !== 16'h0003) begin
      errors++;
      $display("FAIL reset_fwd: got %h want 0003", fwd);
    end
    checks++;
    if ({back, right, left, shoot, esc} !== 80'h0) begin
      errors++;
      $display("FAIL reset_others: got %h %h %h %h %h want all 0000", back, right, left, shoot, esc);
    end
  endtask

  task automatic test_break;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    checks++;
    if (fwd !== 16'h0001) begin
      errors++;
      $display("FAIL break_fwd: got %h want 0001", fwd);
    end
    @(negedge clk) kbd_rst = 1'b1;
    @(negedge clk) kbd_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd !== 16'h0000) begin
      errors++;
      $display("FAIL kbd_clear_fwd: got %h want 0000", fwd);
    end
  endtask

  task automatic test_extended;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h1D, 1'b0);
    checks++;
    if ({fwd, back, right, left, shoot, esc} !== 96'h0) begin
      errors++;
      $display("FAIL ext_make: got %h %h %h %h %h %h want all 0000", fwd, back, right, left, shoot, esc);
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    checks++;
    if ({fwd, back, right, left, shoot, esc} !== 96'h0) begin
      errors++;
      $display("FAIL ext_break: got %h %h %h %h %h %h want all 0000", fwd, back, right, left, shoot, esc);
    end
    send_byte(8'h29, 1'b0);
    checks++;
    if (shoot !== 16'h0003) begin
      errors++;
      $display("FAIL ext_then_shoot: got %h want 0003", shoot);
    end
    checks++;
    if (fwd !== 16'h0000) begin
      errors++;
      $display("FAIL ext_fwd_untouched: got %h want 0000", fwd);
    end
  endtask

  task automatic test_bad_parity;
    int e0;
    e0 = err_cnt;
    send_byte(8'h1C, 1'b1);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL parity_err_pulses: got %0d want 1", err_cnt - e0);
    end
    checks++;
    if (left !== 16'h0000) begin
      errors++;
      $display("FAIL parity_left: got %h want 0000", left);
    end
    send_byte(8'h1C, 1'b0);
    checks++;
    if (left !== 16'h0003) begin
      errors++;
      $display("FAIL parity_recover_left: got %h want 0003", left);
    end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (TIMEOUT + 2) @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL timeout_err_pulses: got %0d want 1", err_cnt - e0);
    end
    send_byte(8'h76, 1'b0);
    checks++;
    if (esc !== 16'h0003) begin
      errors++;
      $display("FAIL timeout_recover_esc: got %h want 0003", esc);
    end
  endtask

  task automatic test_collision;
    logic seen;
    seen = 1'b0;
    send_byte(8'h23, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    checks++;
    if (right !== 16'h0001) begin
      errors++;
      $display("FAIL released_right: got %h want 0001", right);
    end
    @(negedge clk) kbd_rst = 1'b1;
    fork
      send_byte(8'h1B, 1'b0);
      begin
        for (int i = 0; i < 3000 && !seen; i++) begin
          @(posedge clk);
          #1;
          if (back[0] === 1'b1) begin
            seen    = 1'b1;
            kbd_rst = 1'b0;
          end
        end
        kbd_rst = 1'b0;
      end
    join
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL collision_latch_seen: got %b want 1 within 3000 cycles", seen);
    end
    checks++;
    if (back !== 16'h0003) begin
      errors++;
      $display("FAIL collision_back: got %h want 0003", back);
    end
    checks++;
    if (right !== 16'h0000) begin
      errors++;
      $display("FAIL collision_right: got %h want 0000", right);
    end
  endtask

  initial begin
    test_reset;
    test_break;
    test_extended;
    test_bad_parity;
    test_timeout;
    test_collision;
    checks++;
    if (err_cnt !== 2) begin
      errors++;
      $display("FAIL total_frame_err: got %0d want 2", err_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_key_latch.md
Name: ps2_key_latch

Overview:
- Sits directly upstream of the memory controller's keyboard-mapped I/O words.
- Receives PS/2 keyboard frames and decodes set-2 make and break codes for six game keys.
- Presents one 16-bit status word per key: the controller reads these at FORWARD..RESET.
- Consumes the controller's Keyboard_reset strobe, which clears the latched key-press flags.

Parameters:
FILTER_LEN, 4, consecutive equal synchronized samples needed to accept a new ps2_clk level
TIMEOUT, 50000, clk cycles without a filtered falling edge before a partial frame is discarded
CODE_FWD, 8'h1D, scancode for W
CODE_BACK, 8'h1B, scancode for S
CODE_RIGHT, 8'h23, scancode for D
CODE_LEFT, 8'h1C, scancode for A
CODE_SHOOT, 8'h29, scancode for Space
CODE_RESET, 8'h76, scancode for Esc

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_data  in  1  raw PS/2 data (asynchronous)
Keyboard_reset  in  1  clear strobe from the memory controller, level-sampled every clk
FORWARD_Out  out  16  {14'b0, held, latched} for W
BACKWARD_Out  out  16  same format, S
TURNRIGHT_Out  out  16  same format, D
TURNLEFT_Out  out  16  same format, A
SHOOT_Out  out  16  same format, Space
RESET_Out  out  16  same format, Esc
frame_err  out  1  one-cycle pulse on a parity or stop-bit error, or on a timeout

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - While rst_n=0, all *_Out=16'h0000 and frame_err=0.
  - The receive FSM goes to IDLE; the E0 and F0 flags, shift register, bit count, timeout counter and filter all clear.
  - Asserting rst_n mid-frame discards the frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - The filtered clock level changes only after FILTER_LEN consecutive equal synchronized samples.
  - A sample event is a filtered 1->0 transition; ps2_data is sampled on that cycle.
- Receive FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a sample event with data=0 (start bit) goes to DATA and sets bit count to 0. Data=1 stays in IDLE.
  - DATA: 8 sample events shift bits in LSB first. After the 8th, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: a frame is valid when data=1 and the 8 data bits plus parity have odd weight. Then go to IDLE.
  - An invalid frame pulses frame_err for 1 cycle, drops the byte, and returns to IDLE.
  - Timeout: in any state other than IDLE, the counter increments each clk and clears on each sample event. When it reaches TIMEOUT, pulse frame_err and return to IDLE.
- Decoder: acts in the cycle after a valid STOP.
  - byte=E0: set the ext flag.
  - byte=F0: set the brk flag.
  - Any other byte is a code, after which ext and brk both clear.
  - A code with ext=1 is ignored for all six keys.
  - A code with brk=0 is a make: set the matching held and latched bits.
  - A code with brk=1 is a break: clear the matching held bit only.
  - Codes matching no key are ignored.
  - Typematic repeats (repeated make codes) are idempotent.
- Keyboard_reset:
  - Every cycle it is 1, all six latched bits clear; held bits are unaffected.
  - If a make decodes in the same cycle, set wins for that key.
- Latency: held and latched update exactly 1 clk after the clk in which the stop bit is sampled. Outputs are registered.
- Bits [15:2] of every output word are constant 0.

Test Plan:
- Reset: hold rst_n=0 mid-frame, then release and send frame 1D -> every *_Out=0 during reset; after release, FORWARD_Out=16'h0003, other outputs 0.
- Break: send 1D, then F0, then 1D -> after the break, FORWARD_Out=16'h0001; Keyboard_reset pulse -> FORWARD_Out=16'h0000.
- Extended code: send E0 1D, then E0 F0 1D -> all outputs remain 0; a following 29 gives SHOOT_Out=16'h0003.
- Bad parity: send 1C with even parity -> one frame_err pulse, TURNLEFT_Out=0; the next valid 1C gives 16'h0003.
- Timeout: stop ps2_clk after 4 bits, wait TIMEOUT+2 cycles -> one frame_err pulse, FSM back in IDLE; the next frame 76 gives RESET_Out=16'h0003.
- Collision: hold Keyboard_reset=1 in the decode cycle of a 1B make -> BACKWARD_Out=16'h0003 (set wins), while an already-latched D that was released earlier clears to 16'h0000.
